truth_table_sweeper: RTL and testbench

Upstream stimulus and characterisation stage for 3-input logic gates such as the Wolfram-rule gates (e.g. m0x16). It drives in1/in2/in3 through all 8 combinations in ascending order and holds each combination for a settle window. It samples the gate's single output at the end of each window and assembles an 8-bit rule signature. The signature is compared against an expected rule code, so compiled gates can be checked in simulation or on hardware.

---
 rtl/truth_table_sweeper.sv | 111 +++++++++++
 tb/tb_truth_table_sweeper.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 3-input gate through all 8 input combinations,
// holds each for SETTLE_CYCLES, samples the gate output at the end of each
// window and assembles an 8-bit rule signature (input 000 -> bit 7).
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED_RULE = 8'h16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       out_sample,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] rule,
    output logic       match
);

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       rule_q,  rule_d;
    logic             match_q, match_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Next-state logic: sweep sequencing, window counting and signature capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rule_d  = rule_q;
        match_d = match_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    busy_d  = 1'b1;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    rule_d  = 8'h00;
                    match_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    // End of the settle window: this is the only cycle out_sample matters.
                    rule_d[3'd7 - idx_q] = out_sample;
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = 3'd0;  // inputs park at 000 during FINISH/IDLE
                        match_d = (rule_d == EXPECTED_RULE);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any sweep in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            rule_q  <= 8'h00;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rule_q  <= rule_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The index register doubles as the registered gate-input drive.
    assign {in1, in2, in3} = idx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign rule  = rule_q;
    assign match = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 1) each
// driving a modelled 3-input gate; a scoreboard holds the expected signature
// and completion cycle of each accepted sweep, a monitor checks on done.
module tb_truth_table_sweeper;

    typedef struct {
        int         cyc;
        logic [7:0] r;
        logic       m;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start [2];
    logic       out_s [2];
    logic       in1 [2], in2 [2], in3 [2];
    logic       busy [2], done [2], match [2];
    logic [7:0] rule [2];

    logic [7:0] gate_rule [2];
    bit         glitch [2];
    bit         gl_now [2];
    bit         rnd [2];
    int         ph [2];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED_RULE(8'h16)) u_dut4 (
        .clk(clk), .reset(reset), .start(start[0]), .out_sample(out_s[0]),
        .in1(in1[0]), .in2(in2[0]), .in3(in3[0]), .busy(busy[0]), .done(done[0]),
        .rule(rule[0]), .match(match[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED_RULE(8'h16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .out_sample(out_s[1]),
        .in1(in1[1]), .in2(in2[1]), .in3(in3[1]), .busy(busy[1]), .done(done[1]),
        .rule(rule[1]), .match(match[1])
    );

    function automatic int sc(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
        end
    endtask

    // Gate model: truth table lookup, with optional noise outside sample cycles.
    always_comb begin
        for (int d = 0; d < 2; d++)
            out_s[d] = gl_now[d] ? rnd[d] : gate_rule[d][3'd7 - {in1[d], in2[d], in3[d]}];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) ph[d] <= busy[d] ? ph[d] + 1 : 0;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            gl_now[d] = glitch[d] && busy[d] && ((ph[d] % sc(d)) != sc(d) - 1);
            rnd[d]    = 1'($urandom);
        end
    end

    // Monitor: input stepping while busy, and scoreboard pop on each done.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (busy[d]) chk("in_seq", d, {in1[d], in2[d], in3[d]}, ph[d] / sc(d));
            else         chk("in_idle", d, {in1[d], in2[d], in3[d]}, 0);
            if (done[d]) begin
                exp_t e;
                checks++;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    failures++;
                    $display("FAIL spurious_done dut%0d cyc=%0d got=1 want=0", d, cyc);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("done_cyc", d, cyc, e.cyc);
                    chk("rule", d, rule[d], e.r);
                    chk("match", d, match[d], e.m);
                    chk("busy_at_done", d, busy[d], 0);
                end
            end
        end
    end

    task automatic push(int d, int c, logic [7:0] r);
        exp_t e;
        e.cyc = c; e.r = r; e.m = (r == 8'h16);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic run_sweep(int d, logic [7:0] gr, bit gl, bit extra);
        int t;
        gate_rule[d] = gr;
        glitch[d]    = gl;
        @(negedge clk);
        start[d] = 1'b1;
        t = cyc + 1;
        push(d, t + 8 * sc(d), gr);
        @(negedge clk);
        chk("start_busy", d, busy[d], 1);
        chk("start_rule_clr", d, rule[d], 0);
        chk("start_match_clr", d, match[d], 0);
        while (cyc <= t + 8 * sc(d)) begin
            start[d] = extra && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start[d] = 1'b0;
        chk("idle_busy", d, busy[d], 0);
        chk("hold_rule", d, rule[d], gr);
        chk("hold_match", d, match[d], gr == 8'h16);
    endtask

    task automatic reset_mid(int d);
        int k;
        gate_rule[d] = 8'h16;
        glitch[d]    = 1'b0;
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        k = $urandom_range(2, 8 * sc(d) - 2);
        repeat (k) @(negedge clk);
        reset = 1'b1;
        if (d == 0) q0.delete(); else q1.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", d, busy[d], 0);
        chk("rst_done", d, done[d], 0);
        chk("rst_rule", d, rule[d], 0);
        chk("rst_match", d, match[d], 0);
        repeat (8 * sc(d) + 3) @(negedge clk);
        chk("rst_no_resume", d, busy[d], 0);
    endtask

    task automatic held_start(int d, logic [7:0] gr);
        int t1, t2;
        gate_rule[d] = gr;
        glitch[d]    = 1'b0;
        @(negedge clk);
        start[d] = 1'b1;
        t1 = cyc + 1;
        t2 = t1 + 8 * sc(d) + 2;
        push(d, t1 + 8 * sc(d), gr);
        push(d, t2 + 8 * sc(d), gr);
        while (cyc < t1 + 8 * sc(d) + 1) @(negedge clk);
        chk("gap_busy", d, busy[d], 0);
        chk("gap_done", d, done[d], 0);
        while (cyc < t2) @(negedge clk);
        chk("resweep_busy", d, busy[d], 1);
        start[d] = 1'b0;
        while (cyc < t2 + 8 * sc(d) + 2) @(negedge clk);
        chk("after_held_busy", d, busy[d], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; gate_rule[d] = 8'h16; glitch[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("por_busy", d, busy[d], 0);
            chk("por_done", d, done[d], 0);
            chk("por_rule", d, rule[d], 0);
            chk("por_match", d, match[d], 0);
        end
        reset = 1'b0;

        run_sweep(0, 8'h16, 0, 0);
        run_sweep(0, 8'hFF, 0, 0);
        run_sweep(0, 8'h00, 0, 0);
        run_sweep(0, 8'h16, 1, 1);
        reset_mid(0);
        run_sweep(0, 8'h16, 0, 0);
        held_start(0, 8'h16);
        repeat (5) run_sweep(0, 8'($urandom), 1'($urandom), 1'($urandom));

        run_sweep(1, 8'h16, 0, 0);
        reset_mid(1);
        run_sweep(1, 8'h16, 0, 1);
        held_start(1, 8'h6A);
        repeat (5) run_sweep(1, 8'($urandom), 1'($urandom), 1'($urandom));

        repeat (4) @(negedge clk);
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
